// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : ALU control codes and execution-unit state encoding, shared with the ALU control decoder.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_MUL = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   // Codes that finish in the single-cycle datapath.
   function automatic logic is_single_cycle(input logic [3:0] code);
      return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
             (code == ALU_SUB) || (code == ALU_SLT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_add_mul
// Brief    : Iterative shift-add multiplier, one partial product per cycle, low XLEN bits kept.
// Revision : 1.0  initial release
// ============================================================================
module alu_shift_add_mul #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] product
);

   logic             busy_q,   busy_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [XLEN-1:0]  acc_q,    acc_d;
   logic [XLEN-1:0]  mcand_q,  mcand_d;
   logic [XLEN-1:0]  mplier_q, mplier_d;
   logic [XLEN-1:0]  acc_next;

   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   // done is asserted during the final iteration so the caller can register acc_next directly.
   assign done     = busy_q && (cnt_q == CNT_W'(XLEN - 1));
   assign product  = acc_next;
   assign busy     = busy_q;

   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (start) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         acc_d    = '0;
         mcand_d  = a;
         mplier_d = b;
      end else if (busy_q) begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (done) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Execution-stage ALU with valid/ready handshake; ALU_MUL_EN adds the iterative MUL.
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   alu_state_e      state_q,   state_d;
   logic [XLEN-1:0] result_q,  result_d;
   logic            zero_q,    zero_d;
   logic            illegal_q, illegal_d;
   logic [XLEN-1:0] alu_res;
   logic            accept;

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

   // Unsupported codes fall through to zero, which yields result=0 / zero=1.
   always_comb begin
      alu_res = '0;
      case (alu_ctrl)
         ALU_AND: alu_res = op_a & op_b;
         ALU_OR:  alu_res = op_a | op_b;
         ALU_ADD: alu_res = op_a + op_b;
         ALU_SUB: alu_res = op_a - op_b;
         ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   logic            mul_start;
   logic            mul_busy;
   logic            mul_done;
   logic [XLEN-1:0] mul_product;

   alu_shift_add_mul #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
`ifdef ALU_MUL_EN
      mul_start = 1'b0;
`endif
      if (accept) begin
`ifdef ALU_MUL_EN
         if (alu_ctrl == ALU_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
         end else
`endif
         begin
            state_d   = ST_DONE;
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = !is_single_cycle(alu_ctrl);
         end
      end else if ((state_q == ST_DONE) && out_ready) begin
         state_d = ST_IDLE;
      end
`ifdef ALU_MUL_EN
      else if ((state_q == ST_MUL) && mul_done) begin
         state_d   = ST_DONE;
         result_d  = mul_product;
         zero_d    = (mul_product == '0);
         illegal_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Self-checking bench for alu_exec_unit: directed cases plus random ops vs a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;

   localparam int XLEN = 32;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_ctrl;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour straight from the opcode table.
   function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
      ill = 1'b0;
      lat = 1;
      case (c)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0110: r = a - b;
         4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1000: begin
            if (MUL_EN) begin
               r   = a * b;
               lat = XLEN + 1;
            end else begin
               r   = 32'd0;
               ill = 1'b1;
            end
         end
         default: begin
            r   = 32'd0;
            ill = 1'b1;
         end
      endcase
   endfunction

   // Issue one op, corrupt the inputs after accept, wait for the result, stall, then handshake.
   task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input int stall);
      logic [31:0] er;
      logic        ei;
      int          el;
      int          lat;
      bit          saw_ready;
      model(c, a, b, er, ei, el);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      alu_ctrl  = c;
      op_a      = a;
      op_b      = b;
      check({tag, ":in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid  = 1'b0;
      alu_ctrl  = 4'($urandom);
      op_a      = $urandom;
      op_b      = $urandom;
      lat       = 1;
      saw_ready = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) saw_ready = 1'b1;
         @(negedge clk);
         lat++;
      end
      check({tag, ":latency"}, lat, el);
      check({tag, ":result"}, result, er);
      check({tag, ":zero"}, zero, (er == 32'd0));
      check({tag, ":illegal"}, illegal, ei);
      if (el > 1) check({tag, ":busy_ready"}, saw_ready, 0);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         alu_ctrl = 4'b0010;
         op_a     = $urandom;
         @(negedge clk);
         check({tag, ":stall_valid"}, out_valid, 1);
         check({tag, ":stall_result"}, result, er);
         check({tag, ":stall_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ":released"}, out_valid, 0);
   endtask

   logic [3:0]  codes [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b0101};
   logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

   function automatic logic [31:0] rand_operand();
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_ctrl  = 4'b0;
      op_a      = '0;
      op_b      = '0;
      repeat (3) @(negedge clk);
      check("reset:in_ready", in_ready, 1);
      check("reset:out_valid", out_valid, 0);
      check("reset:result", result, 0);
      check("reset:zero", zero, 0);
      check("reset:illegal", illegal, 0);
      rst = 1'b0;

      run_op("add5_7", 4'b0010, 32'd5, 32'd7, 0);
      run_op("sub3_3", 4'b0110, 32'd3, 32'd3, 0);
      run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("stall5", 4'b0001, 32'h1234_0000, 32'h0000_5678, 5);
      run_op("mul", 4'b1000, 32'd1234, 32'd5678, 1);

      // Back-to-back with out_ready held high.
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      alu_ctrl  = 4'b0000;
      op_a      = 32'hF0F0;
      op_b      = 32'h0FF0;
      @(negedge clk);
      check("b2b:valid0", out_valid, 1);
      check("b2b:result0", result, 32'h00F0);
      check("b2b:ready0", in_ready, 1);
      alu_ctrl = 4'b0001;
      op_a     = 32'hF000;
      op_b     = 32'h000F;
      @(negedge clk);
      check("b2b:valid1", out_valid, 1);
      check("b2b:result1", result, 32'hF00F);
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b:idle", out_valid, 0);
      out_ready = 1'b0;

      // Asynchronous reset mid-operation.
      @(negedge clk);
      in_valid = 1'b1;
      alu_ctrl = 4'b1000;
      op_a     = 32'd99;
      op_b     = 32'd77;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort:out_valid", out_valid, 0);
      check("abort:in_ready", in_ready, 1);
      check("abort:result", result, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check("abort:no_result", out_valid, 0);
      run_op("add1_1", 4'b0010, 32'd1, 32'd1, 0);
      run_op("illegal", 4'b0101, 32'd9, 32'd9, 0);

      for (int n = 0; n < 150; n++) begin
         run_op("rand", codes[$urandom_range(0, 6)], rand_operand(), rand_operand(),
                int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
